rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (WriteEn/Waddr/DataIn) among N_REQ writeback requesters: ALU result, load return, and immediate/mov unit.
- Fair round-robin arbitration with valid/ready handshake; the winning write is registered, so the register file sees it one cycle after acceptance.
- Publishes a pending-write mask for the hazard/stall logic and flags starvation while the write port is held.
- Sits between the execute/memory stages and the register file; the register file's MovEn path is untouched.

Parameters:
- W, 8, data path width (matches register file)
- A, 2, register address width (2**A registers)
- N_REQ, 3, number of write requesters
- MAXWAIT, 8, wait cycles after which a requester is flagged starved
- WAITW, 4, wait counter width (must hold MAXWAIT)

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Hold  input  1  freezes arbitration: no grants while 1
- ReqValid  input  N_REQ  per-requester write request
- ReqAddr  input  N_REQ x A  per-requester destination register
- ReqData  input  N_REQ x W  per-requester write data
- ReqReady  output  N_REQ  per-requester grant (one-hot or zero)
- WriteEn  output  1  to register file WriteEn
- Waddr  output  A  to register file Waddr
- DataIn  output  W  to register file DataIn
- PendingMask  output  2**A  registers with an outstanding write
- StarveFlag  output  1  sticky starvation indicator
- StarveClr  input  1  clears StarveFlag

Behaviour:
- Reset (async): WriteEn=0, Waddr=0, DataIn=0, StarveFlag=0, all wait counters=0, round-robin pointer Last=N_REQ-1, so requester 0 has the highest priority first.
- Transfer on requester i occurs when ReqValid[i] & ReqReady[i] at a rising Clk.
- ReqReady is combinational from ReqValid, Hold and Last. At most one bit is set. It is never set for a non-valid requester, and is all-zero when Hold=1.
- Requester contract: valid, addr and data stay stable until transferred.
- Arbitration: scan indices Last+1, Last+2, … mod N_REQ. The first valid requester wins. On a grant, Last <= winner; with no grant, Last holds.
- Output stage (latency 1):
  - Cycle after a grant: WriteEn=1, Waddr/DataIn = winner's addr/data.
  - Cycle after no grant: WriteEn=0; Waddr/DataIn hold their last values.
  - Back-to-back grants give WriteEn=1 on consecutive cycles (throughput one write per cycle).
- Same-address collision: two valid requesters with the same ReqAddr are served in round-robin order on successive cycles. Final register value = the later-granted data. No merging.
- PendingMask[r] = 1 if any valid requester targets r, or if (WriteEn & Waddr==r). This is combinational from the current registers and inputs.
- Wait counters, per requester:
  - Increment (saturating at 2**WAITW-1) each cycle ReqValid & ~ReqReady.
  - Clear on transfer or when ReqValid=0.
  - StarveFlag <= 1 when any counter == MAXWAIT-1 and is incrementing.
  - StarveFlag stays set until StarveClr. If StarveClr and a new starve event happen in the same cycle, set wins.
- Hold asserted mid-stream:
  - The current output-stage write still completes.
  - No new grants; Last frozen; counters of valid requesters keep counting.
- Reset mid-operation: the in-flight output-stage write is dropped (WriteEn forced 0 asynchronously).
- With N_REQ ≤ MAXWAIT and Hold=0, round-robin guarantees StarveFlag never sets.

Decomposition:
- Package rf_arb_pkg holds:
  - constants N_REQ_DEF=3
  - requester index enum REQ_ALU=0, REQ_LOAD=1, REQ_MOV=2
  - typedef for the W/A write beat struct {addr, data}
- Sub-module rr_arbiter (parameter N): inputs req[N], enable, last pointer; outputs one-hot grant and encoded index. This is purely combinational and reusable.
- Pointer, output stage, wait counters and mask live in rf_write_arbiter.

Test Plan:
- Reset then idle: all ReqValid=0 for 5 cycles -> WriteEn=0, Waddr=0, DataIn=0, PendingMask=0000, ReqReady=000.
- Single request: ReqValid=001, ReqAddr0=2, ReqData0=8'hA5 -> ReqReady=001 same cycle; next cycle WriteEn=1, Waddr=2, DataIn=A5; following cycle WriteEn=0.
- All three valid continuously from reset (data 11/22/33, addrs 0/1/2) -> grants in order 0,1,2,0…; WriteEn stays 1 every cycle; Waddr sequence 0,1,2,0.
- Collision: req0 and req2 both target reg 3 (data 8'h10, 8'h20), Last=N_REQ-1 -> req0 written first, then req2; final Waddr=3/DataIn=20; PendingMask[3]=1 until the cycle after the second write.
- Hold: Hold=1 for 10 cycles with req1 valid -> ReqReady=000, WriteEn=0 after the in-flight write; StarveFlag=1 after cycle 8. Release Hold -> req1 granted. StarveClr=1 -> StarveFlag=0 next cycle.
- Async reset mid-write: assert Reset between edges while WriteEn=1 -> WriteEn=0 immediately; after release, req0 wins first.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared definitions for the register-file write-port arbiter:
//   - default sizing constants (data width, address width, requester count,
//     starvation threshold, wait-counter width)
//   - requester index enum (ALU result, load return, immediate/mov unit)
//   - write beat struct {addr, data} at the default sizes
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int W_DEF       = 8;
  localparam int A_DEF       = 2;
  localparam int N_REQ_DEF   = 3;
  localparam int MAXWAIT_DEF = 8;
  localparam int WAITW_DEF   = 4;

  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_MOV  = 2'd2
  } req_idx_e;

  typedef struct packed {
    logic [A_DEF-1:0] addr;
    logic [W_DEF-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans last_i+1, last_i+2, ...
// (mod N) and grants the first asserted request.
// Ports:
//   req_i    [N]  request vector
//   enable_i      when 0 no grant is issued
//   last_i   [IW] index of the most recent winner (lowest priority now)
//   grant_o  [N]  one-hot grant, or zero
//   idx_o    [IW] encoded index of the winner (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic          enable_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int   c;
    logic found;
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_i) + k) % N;
      if (enable_i && !found && req_i[c]) begin
        grant_o[c] = 1'b1;
        idx_o      = IW'(c);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port among N_REQ writeback
// requesters with fair round-robin and a valid/ready handshake. The winning
// beat is registered, so the register file sees it one cycle after transfer.
// Also publishes a pending-write mask and a sticky starvation flag.
// Ports:
//   Clk, Reset          rising-edge clock, async active-high reset
//   Hold                freezes arbitration (no grants, pointer frozen)
//   ReqValid [N_REQ]    per-requester write request
//   ReqAddr  [N_REQ*A]  per-requester destination register (packed, req 0 LSB)
//   ReqData  [N_REQ*W]  per-requester write data (packed, req 0 LSB)
//   ReqReady [N_REQ]    per-requester grant, one-hot or zero
//   WriteEn/Waddr/DataIn  register-file write port
//   PendingMask [2**A]  registers with an outstanding write
//   StarveFlag          sticky: some requester waited MAXWAIT cycles
//   StarveClr           clears StarveFlag (a simultaneous new event wins)
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int A       = A_DEF,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int MAXWAIT = MAXWAIT_DEF,
  parameter int WAITW   = WAITW_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Hold,
  input  logic [N_REQ-1:0]   ReqValid,
  input  logic [N_REQ*A-1:0] ReqAddr,
  input  logic [N_REQ*W-1:0] ReqData,
  output logic [N_REQ-1:0]   ReqReady,
  output logic               WriteEn,
  output logic [A-1:0]       Waddr,
  output logic [W-1:0]       DataIn,
  output logic [(1<<A)-1:0]  PendingMask,
  output logic               StarveFlag,
  input  logic               StarveClr
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win_idx;
  logic             we_q, we_d;
  logic [A-1:0]     waddr_q, waddr_d;
  logic [W-1:0]     data_q, data_d;
  logic [WAITW-1:0] wait_q [N_REQ];
  logic [WAITW-1:0] wait_d [N_REQ];
  logic             starve_q, starve_d;
  logic             starve_evt;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req_i    (ReqValid),
    .enable_i (~Hold),
    .last_i   (last_q),
    .grant_o  (grant),
    .idx_o    (win_idx)
  );

  assign ReqReady   = grant;
  assign WriteEn    = we_q;
  assign Waddr      = waddr_q;
  assign DataIn     = data_q;
  assign StarveFlag = starve_q;

  always_comb begin
    last_d     = last_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;   // address/data hold when no write is issued
    data_d     = data_q;
    starve_evt = 1'b0;
    if (|grant) begin
      last_d  = win_idx;
      we_d    = 1'b1;
      waddr_d = ReqAddr[int'(win_idx)*A +: A];
      data_d  = ReqData[int'(win_idx)*W +: W];
    end
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!ReqValid[i] || grant[i]) begin
        wait_d[i] = '0;
      end else begin
        if (wait_q[i] == WAITW'(MAXWAIT-1)) starve_evt = 1'b1;
        if (wait_q[i] != '1) wait_d[i] = wait_q[i] + 1'b1;
      end
    end
    // A new starve event takes precedence over a same-cycle clear.
    starve_d = starve_evt | (starve_q & ~StarveClr);
  end

  // Mask covers both queued requests and the write currently on the port.
  always_comb begin
    PendingMask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ReqValid[i]) PendingMask[ReqAddr[i*A +: A]] = 1'b1;
    end
    if (we_q) PendingMask[waddr_q] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      last_q   <= IW'(N_REQ-1);
      we_q     <= 1'b0;
      waddr_q  <= '0;
      data_q   <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
    end else begin
      last_q   <= last_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      starve_q <= starve_d;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

endmodule
